// File: rtl/imem_dmem_arbiter.sv
// Purpose : shares one single-port memory between instruction fetch and load/store, one transaction in flight.
// Latency : grant at the IDLE edge, mem_req the next cycle, requester ack one cycle after mem_ack (TIMEOUT cycles max).
// Backpr. : requesters hold req until their one-cycle ack; stall tells the core a request is still pending.
//
// Ports:
//   clk, rst              clock and synchronous active-high reset
//   if_req/if_addr        fetch request (level), returns if_rdata with the one-cycle if_ack pulse
//   d_req/d_we/d_addr/    load/store request (level), returns d_rdata with the one-cycle d_ack pulse
//   d_wdata/d_mask
//   mem_*                 unified memory port; mem_req held until mem_ack
//   err                   flags an ack whose transaction timed out
//   stall                 combinational: some requester has a request without its ack this cycle
module imem_dmem_arbiter #(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int MAX_D_STREAK = 4,
    parameter int TIMEOUT      = 64
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            if_req,
    input  logic [AW-1:0]   if_addr,
    output logic [DW-1:0]   if_rdata,
    output logic            if_ack,

    input  logic            d_req,
    input  logic            d_we,
    input  logic [AW-1:0]   d_addr,
    input  logic [DW-1:0]   d_wdata,
    input  logic [DW/8-1:0] d_mask,
    output logic [DW-1:0]   d_rdata,
    output logic            d_ack,

    output logic            mem_req,
    output logic            mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    output logic [DW/8-1:0] mem_mask,
    input  logic [DW-1:0]   mem_rdata,
    input  logic            mem_ack,

    output logic            err,
    output logic            stall
);

    localparam int MW = DW / 8;
    localparam int SW = $clog2(MAX_D_STREAK + 1);
    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);
    localparam logic [TW-1:0] TCNT_LAST  = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic            grant_d;
    logic            grant_f;
    logic            xfer_done;
    logic            xfer_abort;
    logic            owner_d;     // 1: current transaction belongs to the data side
    logic [SW-1:0]   streak;
    logic [TW-1:0]   tcnt;
    logic [DW-1:0]   resp_dat;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next state and grant decisions
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt  = state;
        grant_d    = 1'b0;
        grant_f    = 1'b0;
        xfer_done  = 1'b0;
        xfer_abort = 1'b0;
        case (state)
            IDLE: begin
                // Data has priority unless fetch has been passed over too often.
                if (d_req && !(if_req && streak == STREAK_MAX)) begin
                    grant_d   = 1'b1;
                    state_nxt = BUSY;
                end else if (if_req) begin
                    grant_f   = 1'b1;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (mem_ack) begin
                    xfer_done = 1'b1;
                    state_nxt = RESP;
                end else if (tcnt == TCNT_LAST) begin
                    xfer_abort = 1'b1;
                    state_nxt  = RESP;
                end
            end
            RESP: begin
                // Forced turnaround: no grant here, so a requester that keeps
                // req high is only seen again once the ack has been consumed.
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Stores and aborted transactions return zero data.
    assign resp_dat = (xfer_done && !mem_we) ? mem_rdata : '0;

    // ------------------------------------------------------------------
    // Registered datapath: memory request, counters, responses
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_d   <= 1'b0;
            streak    <= '0;
            tcnt      <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_mask  <= '0;
            if_ack    <= 1'b0;
            if_rdata  <= '0;
            d_ack     <= 1'b0;
            d_rdata   <= '0;
            err       <= 1'b0;
        end else begin
            // Acks and err are single-cycle pulses.
            if_ack <= 1'b0;
            d_ack  <= 1'b0;
            err    <= 1'b0;

            case (state)
                IDLE: begin
                    tcnt <= '0;
                    if (grant_d) begin
                        owner_d   <= 1'b1;
                        mem_req   <= 1'b1;
                        mem_we    <= d_we;
                        mem_addr  <= d_addr;
                        mem_wdata <= d_wdata;
                        mem_mask  <= d_mask;
                        // Only data grants that bypass a waiting fetch count.
                        if (!if_req) begin
                            streak <= '0;
                        end else if (streak != STREAK_MAX) begin
                            streak <= streak + 1'b1;
                        end
                    end else if (grant_f) begin
                        owner_d   <= 1'b0;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_addr  <= if_addr;
                        mem_wdata <= '0;
                        mem_mask  <= {MW{1'b1}};
                        streak    <= '0;
                    end
                end
                BUSY: begin
                    tcnt <= tcnt + 1'b1;
                    if (xfer_done || xfer_abort) begin
                        mem_req <= 1'b0;
                        err     <= xfer_abort;
                        if (owner_d) begin
                            d_ack   <= 1'b1;
                            d_rdata <= resp_dat;
                        end else begin
                            if_ack   <= 1'b1;
                            if_rdata <= resp_dat;
                        end
                    end
                end
                default: begin
                    tcnt <= '0;
                end
            endcase
        end
    end

    assign stall = (if_req & ~if_ack) | (d_req & ~d_ack);

endmodule
